// File: rtl/br_pkg.sv
// Shared types and helpers for the branch resolution controller.
// Used by branch_resolver and br_cmp.
package br_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResolve,
    StDone
  } br_state_e;

  // Branch condition encodings; 6 and 7 are reserved (never taken)
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LEZ = 3'd2;
  localparam logic [2:0] CMP_GTZ = 3'd3;
  localparam logic [2:0] CMP_LTZ = 3'd4;
  localparam logic [2:0] CMP_GEZ = 3'd5;

  // Which source operands a condition has to wait for
  typedef struct packed {
    logic rt;
    logic rs;
  } op_need_t;

  function automatic op_need_t needed_ops(input logic [2:0] sel);
    op_need_t need;
    need = '0;
    case (sel)
      CMP_EQ, CMP_NE: begin
        need.rs = 1'b1;
        need.rt = 1'b1;
      end
      CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ: begin
        need.rs = 1'b1;
      end
      default: ;
    endcase
    return need;
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Combinational branch condition comparator. Reserved selects resolve not-taken.
module br_cmp
  import br_pkg::*;
(
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = i_rs[31];
  assign w_rs_zero = (i_rs == 32'd0);

  // Decode the condition; signed compares against zero reduce to sign/zero tests
  always_comb begin
    o_taken = 1'b0;
    case (i_sel)
      CMP_EQ:  o_taken = (i_rs == i_rt);
      CMP_NE:  o_taken = (i_rs != i_rt);
      CMP_LEZ: o_taken = w_rs_neg | w_rs_zero;
      CMP_GTZ: o_taken = ~w_rs_neg & ~w_rs_zero;
      CMP_LTZ: o_taken = w_rs_neg;
      CMP_GEZ: o_taken = ~w_rs_neg;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Multi-cycle branch resolution controller for the decode stage.
// Holds one branch until its operands arrive, resolves it through br_cmp,
// then emits a registered outcome/redirect pulse. Owns the decode stall.
// Optional feature: define BRANCH_STATS_EN to add taken/not-taken/wait counters.
module branch_resolver
  import br_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_sel,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [15:0]       br_off,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic              rs_rdy,
  input  logic              rt_rdy,
  input  logic              flush_in,
  output logic              stall,
  output logic              resolve_valid,
  output logic              taken,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              wait_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_not_taken,
  output logic [31:0]       stat_wait
`endif
);

  // Counter saturates one past WAIT_MAX; that value flags the timeout
  localparam int unsigned CntW = $clog2(WAIT_MAX + 2);
  localparam logic [CntW-1:0] CntSat = CntW'(WAIT_MAX + 1);

  br_state_e r_state;
  br_state_e w_state_nxt;

  logic [2:0]        r_sel;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_off;
  logic [31:0]       r_rs;
  logic [31:0]       r_rt;
  logic [CntW-1:0]   r_wait_cnt;
  logic [CntW-1:0]   w_wait_cnt_nxt;
  logic              r_wait_err;
  logic              r_taken;
  logic              r_resolve_valid;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;

  op_need_t          w_need;
  logic              w_ops_rdy;
  logic              w_accept;
  logic              w_capture;
  logic              w_resolve;
  logic              w_cmp_taken;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_target;

  assign w_need    = needed_ops(r_sel);
  assign w_ops_rdy = (~w_need.rs | rs_rdy) & (~w_need.rt | rt_rdy);
  assign w_accept  = (r_state == StIdle) && br_valid && !flush_in;
  assign w_capture = (r_state == StWait) && w_ops_rdy && !flush_in;
  assign w_resolve = (r_state == StResolve) && !flush_in;

  // Word offset, sign-extended and scaled; the sum wraps at ADDR_W bits
  assign w_off_ext = {{(ADDR_W - 16){r_off[15]}}, r_off};
  assign w_target  = r_pc + ADDR_W'(32'd4) + (w_off_ext << 2);

  br_cmp u_br_cmp (
    .i_sel   (r_sel),
    .i_rs    (r_rs),
    .i_rt    (r_rt),
    .o_taken (w_cmp_taken)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    w_state_nxt = r_state;
    if (flush_in) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:    if (br_valid) w_state_nxt = StWait;
        StWait:    if (w_ops_rdy) w_state_nxt = StResolve;
        StResolve: w_state_nxt = StDone;
        StDone:    w_state_nxt = StIdle;
        default:   w_state_nxt = StIdle;
      endcase
    end
  end

  // Wait counter next value: clear on accept, count unready WAIT cycles, saturate
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_accept) begin
      w_wait_cnt_nxt = '0;
    end else if ((r_state == StWait) && !w_ops_rdy && (r_wait_cnt != CntSat)) begin
      w_wait_cnt_nxt = r_wait_cnt + 1'b1;
    end
  end

  // Wait counter and sticky timeout flag (flush does not clear the flag)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_wait_err <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_wait_cnt_nxt == CntSat) begin
        r_wait_err <= 1'b1;
      end
    end
  end

  // Request and operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_pc  <= '0;
      r_off <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
    end else begin
      if (w_accept) begin
        r_sel <= br_sel;
        r_pc  <= br_pc;
        r_off <= br_off;
      end
      if (w_capture) begin
        r_rs <= rs_val;
        r_rt <= rt_val;
      end
    end
  end

  // Outcome registers; pulses are high exactly in DONE and never after a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken          <= 1'b0;
      r_redirect_pc    <= '0;
      r_resolve_valid  <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_resolve_valid  <= w_resolve;
      r_redirect_valid <= w_resolve & w_cmp_taken;
      if (w_resolve) begin
        r_taken       <= w_cmp_taken;
        r_redirect_pc <= w_target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_not_taken;
  logic [31:0] r_stat_wait;

  // Statistics counters; free-running wrap, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
      r_stat_wait      <= '0;
    end else begin
      if (r_state == StDone) begin
        if (r_taken) begin
          r_stat_taken <= r_stat_taken + 32'd1;
        end else begin
          r_stat_not_taken <= r_stat_not_taken + 32'd1;
        end
      end
      if (r_state == StWait) begin
        r_stat_wait <= r_stat_wait + 32'd1;
      end
    end
  end

  assign stat_taken     = r_stat_taken;
  assign stat_not_taken = r_stat_not_taken;
  assign stat_wait      = r_stat_wait;
`endif

  assign br_ready       = (r_state == StIdle);
  assign stall          = (r_state != StIdle);
  assign resolve_valid  = r_resolve_valid;
  assign redirect_valid = r_redirect_valid;
  assign taken          = r_taken;
  assign redirect_pc    = r_redirect_pc;
  assign wait_err       = r_wait_err;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus pushes expected outcomes,
// a monitor pops and compares on every resolve pulse.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_sel;
  logic [31:0] br_pc;
  logic [15:0] br_off;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_rdy;
  logic        rt_rdy;
  logic        flush_in;
  logic        stall;
  logic        resolve_valid;
  logic        taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wait_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken;
  logic [31:0] stat_not_taken;
  logic [31:0] stat_wait;
`endif

  branch_resolver #(
    .ADDR_W   (32),
    .WAIT_MAX (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_sel         (br_sel),
    .br_pc          (br_pc),
    .br_off         (br_off),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .rs_rdy         (rs_rdy),
    .rt_rdy         (rt_rdy),
    .flush_in       (flush_in),
    .stall          (stall),
    .resolve_valid  (resolve_valid),
    .taken          (taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .wait_err       (wait_err)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken),
    .stat_wait      (stat_wait)
`endif
  );

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: branch semantics straight from the condition definitions
  function automatic logic ref_taken(input logic [2:0] sel, input logic [31:0] rs,
                                     input logic [31:0] rt);
    int a;
    a = int'(rs);
    case (sel)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return a <= 0;
      3'd3:    return a > 0;
      3'd4:    return a < 0;
      3'd5:    return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off);
    int soff;
    soff = int'($signed(off));
    return pc + 32'd4 + 32'(soff * 4);
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'h8000_0000 | 32'($urandom);
      2:       return 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every resolve pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid && !resolve_valid) chk("redirect_without_resolve", 32'd1, 32'd0);
      if (resolve_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("taken", {31'd0, taken}, {31'd0, e.tk});
          chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.tk});
          chk("redirect_pc", redirect_pc, e.tgt);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One branch from accept to return-to-IDLE. d_rs/d_rt: WAIT cycles with flag low.
  // flush_k: cycle offset from accept at which flush_in pulses (0 = none).
  task automatic issue(input logic [2:0] sel, input logic [31:0] pc, input logic [15:0] off,
                       input logic [31:0] rs, input logic [31:0] rt, input int d_rs,
                       input int d_rt, input int flush_k, input bit err_chk);
    int   n0, w, last;
    logic need_rs, need_rt;
    chk("br_ready_idle", {31'd0, br_ready}, 32'd1);
    chk("stall_idle", {31'd0, stall}, 32'd0);
    need_rs = (sel <= 3'd5);
    need_rt = (sel <= 3'd1);
    w = 1;
    if (need_rs && d_rs + 1 > w) w = d_rs + 1;
    if (need_rt && d_rt + 1 > w) w = d_rt + 1;
    n0 = cyc;
    br_valid = 1'b1;
    br_sel   = sel;
    br_pc    = pc;
    br_off   = off;
    // Readiness and values in the accept cycle must be ignored
    rs_rdy   = 1'($urandom);
    rt_rdy   = 1'($urandom);
    rs_val   = $urandom;
    rt_val   = $urandom;
    if (flush_k == 0 || flush_k > w + 1) begin
      sb_q.push_back('{ref_taken(sel, rs, rt), ref_target(pc, off), n0 + w + 2});
    end
    last = (flush_k > 0) ? flush_k : w + 2;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      br_valid = 1'($urandom);
      br_sel   = 3'($urandom);
      br_pc    = $urandom;
      br_off   = 16'($urandom);
      rs_rdy   = (k > d_rs);
      rt_rdy   = (k > d_rt);
      rs_val   = rs_rdy ? rs : $urandom;
      rt_val   = rt_rdy ? rt : $urandom;
      flush_in = (k == flush_k);
      chk("stall_busy", {31'd0, stall}, 32'd1);
      if (err_chk && k == 15) chk("wait_err_early", {31'd0, wait_err}, 32'd0);
      if (err_chk && k == 17) chk("wait_err_set", {31'd0, wait_err}, 32'd1);
    end
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    flush_in = 1'b0;
    rs_rdy   = 1'b0;
    rt_rdy   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    br_valid = 1'b0;
    br_sel   = '0;
    br_pc    = '0;
    br_off   = '0;
    rs_val   = '0;
    rt_val   = '0;
    rs_rdy   = 1'b0;
    rt_rdy   = 1'b0;
    flush_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_wait_err", {31'd0, wait_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // beq taken, no wait
    issue(3'd0, 32'h0000_3000, 16'h0004, 32'd5, 32'd5, 0, 0, 0, 1'b0);
    // bne with equal operands: resolves not-taken
    issue(3'd1, 32'h0040_0100, 16'h0010, 32'd7, 32'd7, 0, 0, 0, 1'b0);
    // bltz with rs late by 3 cycles, negative offset
    issue(3'd4, 32'h0000_3000, 16'hFFFF, 32'h8000_0000, 32'd0, 3, 0, 0, 1'b0);
    // flush in RESOLVE, then a request accepted right away
    issue(3'd0, 32'h0000_1000, 16'h0001, 32'd9, 32'd9, 0, 0, 2, 1'b0);
    issue(3'd5, 32'h0000_2000, 16'h0002, 32'd1, 32'd0, 0, 0, 0, 1'b0);
    // target wraps modulo 2^32
    issue(3'd3, 32'hFFFF_FFF0, 16'h0007, 32'd1, 32'd0, 1, 0, 0, 1'b0);

    // Randomized traffic with occasional flushes and idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  sel;
      logic [31:0] rs, rt;
      int          d_rs, d_rt, fk, w;
      sel  = 3'($urandom);
      rs   = pick_val();
      rt   = ($urandom_range(0, 2) == 0) ? rs : pick_val();
      d_rs = $urandom_range(0, 4);
      d_rt = $urandom_range(0, 4);
      w    = 1;
      if (sel <= 3'd5 && d_rs + 1 > w) w = d_rs + 1;
      if (sel <= 3'd1 && d_rt + 1 > w) w = d_rt + 1;
      fk   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, w + 2) : 0;
      issue(sel, $urandom, 16'($urandom), rs, rt, d_rs, d_rt, fk, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Wait timeout: rt unavailable for 16 WAIT cycles
    chk("wait_err_before", {31'd0, wait_err}, 32'd0);
    issue(3'd0, 32'h0000_5000, 16'h0003, 32'd4, 32'd4, 0, 16, 0, 1'b1);
    chk("wait_err_after_done", {31'd0, wait_err}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("stat_wait_min", {31'd0, stat_wait >= 32'd16}, 32'd1);
`endif
    issue(3'd2, 32'h0000_6000, 16'h0001, 32'd0, 32'd0, 2, 0, 2, 1'b0);
    chk("wait_err_after_flush", {31'd0, wait_err}, 32'd1);

    // Asynchronous reset while in WAIT
    br_valid = 1'b1;
    br_sel   = 3'd0;
    br_pc    = 32'h0000_7000;
    br_off   = 16'h0001;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_br_ready", {31'd0, br_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
    chk("mid_rst_taken", {31'd0, taken}, 32'd0);
    chk("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("mid_rst_redirect_pc", redirect_pc, 32'd0);
    chk("mid_rst_wait_err", {31'd0, wait_err}, 32'd0);
    #1;
    rst_n  = 1'b1;
    rs_rdy = 1'b1;
    rt_rdy = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("post_reset_stall", {31'd0, stall}, 32'd0);
    rs_rdy = 1'b0;
    rt_rdy = 1'b0;
    issue(3'd0, 32'h0000_8000, 16'h0002, 32'd3, 32'd3, 1, 2, 0, 1'b0);

    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
